// File: rtl/conv_layer_driver.sv
// Drives a 15-product / 5-accumulate 1-D convolution (7-wide image, 3-tap filter)
// through an external conv layer and captures its five results locally.
module conv_layer_driver #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LoadEn,
    input  logic       LoadSel,
    input  logic [2:0] LoadAddr,
    input  logic [3:0] LoadData,
    input  logic       Go,
    output logic       Busy,
    output logic       Done,
    output logic       Start,
    output logic [3:0] Image,
    output logic [3:0] Filter,
    output logic       ReadEn,
    input  logic [9:0] ConvResult,
    input  logic [2:0] ResAddr,
    output logic [9:0] ResData
);
    localparam int DATA_W = 4;
    localparam int COEF_W = 4;
    localparam int RES_W  = 10;
    localparam int N_IMG  = 7;
    localparam int N_FLT  = 3;
    localparam int N_RES  = 5;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        GAP,
        READ,
        DRAIN,
        DONE
    } stateT;

    stateT state, stateNext;

    logic [DATA_W-1:0] img [0:N_IMG-1];
    logic [COEF_W-1:0] flt [0:N_FLT-1];
    logic [RES_W-1:0]  res [0:N_RES-1];

    logic [3:0]        multCnt;
    logic [2:0]        kIdx;
    logic [1:0]        jIdx;
    logic [2:0]        readCnt;
    logic [2:0]        capIdx;
    logic [RD_LAT-1:0] rdVld_p;
    logic              capHit;
    logic [2:0]        imgIdx;

    assign capHit = rdVld_p[RD_LAT-1];
    assign imgIdx = kIdx + {1'b0, jIdx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (Go) stateNext = MULT;
            MULT:  if (multCnt == 4'd14) stateNext = GAP;
            GAP:   stateNext = READ;
            READ:  if (readCnt == 3'd4) stateNext = DRAIN;
            // Look ahead at the final capture so DONE follows it directly.
            DRAIN: if (capIdx == 3'd5 || (capHit && capIdx == 3'd4)) stateNext = DONE;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        Busy   = (state != IDLE);
        Done   = (state == DONE);
        Start  = 1'b0;
        ReadEn = 1'b0;
        Image  = '0;
        Filter = '0;
        if (state == MULT) begin
            Start  = 1'b1;
            Image  = img[imgIdx];
            Filter = flt[jIdx];
        end
        if (state == READ) begin
            ReadEn = 1'b1;
        end
    end

    assign ResData = (ResAddr < 3'd5) ? res[ResAddr] : '0;

    // MULT walks p = 3k + j; READ walks the five result slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multCnt <= '0;
            kIdx    <= '0;
            jIdx    <= '0;
            readCnt <= '0;
        end else begin
            if (state == MULT) begin
                multCnt <= multCnt + 4'd1;
                if (jIdx == 2'd2) begin
                    jIdx <= '0;
                    kIdx <= kIdx + 3'd1;
                end else begin
                    jIdx <= jIdx + 2'd1;
                end
            end else begin
                multCnt <= '0;
                kIdx    <= '0;
                jIdx    <= '0;
            end
            readCnt <= (state == READ) ? readCnt + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IMG; i++) img[i] <= '0;
            for (int i = 0; i < N_FLT; i++) flt[i] <= '0;
        end else if (state == IDLE && LoadEn) begin
            if (!LoadSel && LoadAddr < 3'd7) begin
                img[LoadAddr] <= LoadData;
            end
            if (LoadSel && LoadAddr < 3'd3) begin
                flt[LoadAddr[1:0]] <= LoadData;
            end
        end
    end

    // Read-valid delay line: stage RD_LAT-1 lines up with ConvResult.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdVld_p <= '0;
            capIdx  <= '0;
            for (int i = 0; i < N_RES; i++) res[i] <= '0;
        end else begin
            rdVld_p <= RD_LAT'({rdVld_p, ReadEn});
            if (state == IDLE && Go) begin
                capIdx <= '0;
            end else if (capHit && capIdx < 3'd5) begin
                res[capIdx] <= ConvResult;
                capIdx      <= capIdx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_driver.sv
// Bench for conv_layer_driver: two instances (RD_LAT 1 and 3) share stimulus, each
// paired with a behavioural conv layer; results are checked through a scoreboard queue.
module tb_conv_layer_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, LoadEn, LoadSel, Go;
    logic [2:0] LoadAddr, ResAddr;
    logic [3:0] LoadData;

    logic       busyA, doneA, startA, readEnA, busyB, doneB, startB, readEnB;
    logic [3:0] imageA, filterA, imageB, filterB;
    logic [9:0] convA, resDataA, convB, resDataB;

    conv_layer_driver #(.RD_LAT(1)) dutA (
        .clk(clk), .rst_n(rst_n), .LoadEn(LoadEn), .LoadSel(LoadSel), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Go(Go), .Busy(busyA), .Done(doneA), .Start(startA),
        .Image(imageA), .Filter(filterA), .ReadEn(readEnA), .ConvResult(convA),
        .ResAddr(ResAddr), .ResData(resDataA));

    conv_layer_driver #(.RD_LAT(3)) dutB (
        .clk(clk), .rst_n(rst_n), .LoadEn(LoadEn), .LoadSel(LoadSel), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .Go(Go), .Busy(busyB), .Done(doneB), .Start(startB),
        .Image(imageB), .Filter(filterB), .ReadEn(readEnB), .ConvResult(convB),
        .ResAddr(ResAddr), .ResData(resDataB));

    // Conv layer models: write products at a wrapping pointer, sum triples on read.
    int memA [15];
    int memB [15];
    int wpA, rpA, wpB, rpB;
    logic [9:0] s1B, s2B;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wpA <= 0; rpA <= 0; convA <= '0;
        end else begin
            if (startA) begin
                memA[wpA] <= int'(imageA) * int'(filterA);
                wpA <= (wpA == 14) ? 0 : wpA + 1;
            end
            if (readEnA) begin
                convA <= 10'(memA[3*rpA] + memA[3*rpA+1] + memA[3*rpA+2]);
                rpA <= (rpA == 4) ? 0 : rpA + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wpB <= 0; rpB <= 0; s1B <= '0; s2B <= '0; convB <= '0;
        end else begin
            if (startB) begin
                memB[wpB] <= int'(imageB) * int'(filterB);
                wpB <= (wpB == 14) ? 0 : wpB + 1;
            end
            s1B <= '0;
            if (readEnB) begin
                s1B <= 10'(memB[3*rpB] + memB[3*rpB+1] + memB[3*rpB+2]);
                rpB <= (rpB == 4) ? 0 : rpB + 1;
            end
            s2B   <= s1B;
            convB <= s2B;
        end
    end

    typedef struct packed {
        logic [6:0][3:0] img;
        logic [2:0][3:0] flt;
        logic [4:0][9:0] res;
    } vecT;

    vecT vecs [4];
    int  qA [$];
    int  qB [$];
    int  nChecks = 0;
    int  nPass = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic checkPair(input string name, input int v, input int p,
                             input logic [3:0] im, input logic [3:0] fl);
        if (p < 15) check(name, int'({im, fl}), int'({vecs[v].img[p/3 + p%3], vecs[v].flt[p%3]}));
        else check(name, p, 14);
    endtask

    task automatic doLoad(input logic sel, input logic [2:0] addr, input logic [3:0] data);
        @(negedge clk);
        LoadEn = 1'b1; LoadSel = sel; LoadAddr = addr; LoadData = data;
        @(posedge clk); #1;
        LoadEn = 1'b0;
    endtask

    // flt[0] is deliberately left for the Go cycle, so every run uses a same-cycle load.
    task automatic loadVec(input int v, input bit withImg);
        if (withImg) for (int i = 0; i < 7; i++) doLoad(1'b0, 3'(i), vecs[v].img[i]);
        for (int i = 1; i < 3; i++) doLoad(1'b1, 3'(i), vecs[v].flt[i]);
        doLoad(1'b0, 3'd7, 4'd15);
        doLoad(1'b1, 3'd5, 4'd15);
        doLoad(1'b1, 3'd6, 4'd15);
    endtask

    task automatic runVec(input int v, input bit interfere, input int abortAt);
        int pA, pB, rdA, rdB, dcA, dcB, datA, datB, eA, eB;
        pA = 0; pB = 0; rdA = 0; rdB = 0; dcA = 0; dcB = 0; datA = -1; datB = -1;
        ResAddr = 3'd0;
        if (abortAt == 0) begin
            for (int k = 0; k < 5; k++) begin
                qA.push_back(int'(vecs[v].res[k]));
                qB.push_back(int'(vecs[v].res[k]));
            end
        end
        @(negedge clk);
        Go = 1'b1; LoadEn = 1'b1; LoadSel = 1'b1; LoadAddr = 3'd0; LoadData = vecs[v].flt[0];
        @(posedge clk); #1;
        Go = 1'b0; LoadEn = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 1) begin
                check("busyStartA", int'(busyA), 1);
                check("busyStartB", int'(busyB), 1);
            end
            if (startA) begin checkPair("opsA", v, pA, imageA, filterA); pA++; end
            else check("idleOpsA", int'(imageA) + int'(filterA), 0);
            if (startB) begin checkPair("opsB", v, pB, imageB, filterB); pB++; end
            else check("idleOpsB", int'(imageB) + int'(filterB), 0);
            if (readEnA) rdA++;
            if (readEnB) rdB++;
            if (doneA) begin dcA++; datA = cyc; check("busyAtDoneA", int'(busyA), 1); end
            if (doneB) begin dcB++; datB = cyc; check("busyAtDoneB", int'(busyB), 1); end
            if (interfere) begin
                if (cyc == 5) Go = 1'b1;
                if (cyc == 6) Go = 1'b0;
                if (cyc == 18) begin LoadEn = 1'b1; LoadSel = 1'b0; LoadAddr = 3'd0; LoadData = 4'd9; end
                if (cyc == 19) LoadEn = 1'b0;
            end
            if (abortAt != 0 && cyc == abortAt) break;
            @(posedge clk); #1;
        end

        if (abortAt != 0) begin
            #2; rst_n = 1'b0; #1;
            check("rstOutsA", int'({busyA, doneA, startA, readEnA, imageA, filterA, resDataA}), 0);
            check("rstOutsB", int'({busyB, doneB, startB, readEnB, imageB, filterB, resDataB}), 0);
            repeat (3) @(posedge clk);
            @(negedge clk); rst_n = 1'b1;
            dcA = 0; dcB = 0;
            repeat (30) begin
                @(posedge clk); #1;
                if (doneA) dcA++;
                if (doneB) dcB++;
            end
            check("abortDoneA", dcA, 0);
            check("abortDoneB", dcB, 0);
            check("abortIdleA", int'(busyA), 0);
            check("abortIdleB", int'(busyB), 0);
            for (int k = 0; k < 5; k++) begin
                ResAddr = 3'(k); #1;
                check("rstResA", int'(resDataA), 0);
                check("rstResB", int'(resDataB), 0);
            end
        end else begin
            check("startsA", pA, 15);
            check("startsB", pB, 15);
            check("readsA", rdA, 5);
            check("readsB", rdB, 5);
            check("doneCntA", dcA, 1);
            check("doneCntB", dcB, 1);
            check("doneAtA", datA, 1 + 15 + 1 + 5 + 1);
            check("doneAtB", datB, 1 + 15 + 1 + 5 + 3);
            check("idleAfterA", int'(busyA), 0);
            check("idleAfterB", int'(busyB), 0);
            for (int k = 0; k < 8; k++) begin
                ResAddr = 3'(k); #1;
                if (k < 5) begin
                    eA = (qA.size() > 0) ? qA.pop_front() : -1;
                    eB = (qB.size() > 0) ? qB.pop_front() : -1;
                end else begin
                    eA = 0; eB = 0;
                end
                check("resA", int'(resDataA), eA);
                check("resB", int'(resDataB), eB);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; LoadEn = 1'b0; LoadSel = 1'b0; LoadAddr = '0; LoadData = '0;
        Go = 1'b0; ResAddr = '0;

        for (int i = 0; i < 7; i++) begin
            vecs[0].img[i] = 4'(i + 1);
            vecs[1].img[i] = 4'd15;
            vecs[2].img[i] = 4'(i + 1);
        end
        vecs[0].flt[0] = 4'd1;  vecs[0].flt[1] = 4'd2;  vecs[0].flt[2] = 4'd3;
        vecs[0].res[0] = 10'd14; vecs[0].res[1] = 10'd20; vecs[0].res[2] = 10'd26;
        vecs[0].res[3] = 10'd32; vecs[0].res[4] = 10'd38;
        for (int i = 0; i < 3; i++) vecs[1].flt[i] = 4'd15;
        for (int i = 0; i < 5; i++) vecs[1].res[i] = 10'd675;
        vecs[2].flt[0] = 4'd0;  vecs[2].flt[1] = 4'd0;  vecs[2].flt[2] = 4'd1;
        for (int i = 0; i < 5; i++) vecs[2].res[i] = 10'(i + 3);
        vecs[3].img[0] = 4'd2; vecs[3].img[1] = 4'd0; vecs[3].img[2] = 4'd5; vecs[3].img[3] = 4'd1;
        vecs[3].img[4] = 4'd9; vecs[3].img[5] = 4'd4; vecs[3].img[6] = 4'd8;
        vecs[3].flt[0] = 4'd3;  vecs[3].flt[1] = 4'd7;  vecs[3].flt[2] = 4'd1;
        vecs[3].res[0] = 10'd11; vecs[3].res[1] = 10'd36; vecs[3].res[2] = 10'd31;
        vecs[3].res[3] = 10'd70; vecs[3].res[4] = 10'd63;

        #12;
        check("resetOutsA", int'({busyA, doneA, startA, readEnA, imageA, filterA, resDataA}), 0);
        check("resetOutsB", int'({busyB, doneB, startB, readEnB, imageB, filterB, resDataB}), 0);
        @(negedge clk); rst_n = 1'b1;

        loadVec(0, 1'b1); runVec(0, 1'b0, 0);
        loadVec(1, 1'b1); runVec(1, 1'b0, 0);
        loadVec(3, 1'b1); runVec(3, 1'b0, 8);
        loadVec(3, 1'b1); runVec(3, 1'b0, 0);
        loadVec(0, 1'b1); runVec(0, 1'b1, 0);
        runVec(0, 1'b0, 0);
        loadVec(2, 1'b0); runVec(2, 1'b0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/conv_layer_driver.md
CONV_LAYER_DRIVER -- requirements
Module: conv_layer_driver

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from ReadEn high to the matching valid ConvResult; legal range 1..3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 LoadEn  input  1  write one coefficient into the local buffers.
REQ-005 LoadSel  input  1  0 = image buffer, 1 = filter buffer.
REQ-006 LoadAddr  input  3  buffer index: image 0..6, filter 0..2.
REQ-007 LoadData  input  4  unsigned value to store.
REQ-008 Go  input  1  single-cycle run request.
REQ-009 Busy  output  1  high while a run is in progress.
REQ-010 Done  output  1  one-cycle pulse when all 5 results are captured.
REQ-011 Start  output  1  multiply/write strobe toward the conv layer.
REQ-012 Image  output  4  image operand toward the conv layer.
REQ-013 Filter  output  4  filter operand toward the conv layer.
REQ-014 ReadEn  output  1  read/accumulate strobe toward the conv layer.
REQ-015 ConvResult  input  10  accumulated 3-tap result from the conv layer.
REQ-016 ResAddr  input  3  result index 0..4 for readout.
REQ-017 ResData  output  10  combinational read of result[ResAddr]; 0 when ResAddr > 4.

Function
REQ-018 Local storage SHALL be img[0..6] x 4b, flt[0..2] x 4b and res[0..4] x 10b.
REQ-019 A load SHALL be accepted only in IDLE; it writes on the clock edge where LoadEn=1, and out-of-range LoadAddr is ignored.
REQ-020 FSM states SHALL be IDLE, MULT, GAP, READ, DRAIN and DONE.
REQ-021 IDLE -> MULT on Go=1; Go outside IDLE SHALL be ignored.
REQ-022 If Go and LoadEn are high in the same IDLE cycle, the load SHALL complete and the run SHALL use the new value.
REQ-023 MULT SHALL last exactly 15 cycles with Start=1, using counter p = 0..14, k = p/3, j = p%3.
REQ-024 In each MULT cycle p, Image SHALL be img[k+j] and Filter SHALL be flt[j], so the conv layer's write address p holds img[k+j]*flt[j].
REQ-025 Exactly 15 Start cycles SHALL be issued per run so the layer's write counter wraps back to 0.
REQ-026 GAP SHALL be one cycle with Start=0 and ReadEn=0.
REQ-027 READ SHALL last exactly 5 cycles with ReadEn=1, one cycle for each result k = 0..4.
REQ-028 Outside MULT and READ, Start and ReadEn SHALL be 0, and Image and Filter SHALL be 0.
REQ-029 Capture: a ReadEn delay line of depth RD_LAT SHALL be kept; when its output is 1, ConvResult SHALL be written to res[cap_idx] and cap_idx incremented, cap_idx being cleared on entry to MULT.
REQ-030 DRAIN SHALL hold until cap_idx = 5, then go to DONE.
REQ-031 DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-032 Busy SHALL be 1 in MULT, GAP, READ, DRAIN and DONE, and 0 in IDLE.
REQ-033 Arithmetic SHALL be unsigned; the maximum result is 3*15*15 = 675, which fits in 10 bits with no saturation.
REQ-034 res[] SHALL hold its values until the next run's capture overwrites each entry, or until reset.
REQ-035 Total run time from Go to Done SHALL be 1+15+1+5+RD_LAT cycles, ending with the Done cycle.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, and clear every counter, the delay line, img, flt and res.
REQ-037 During reset, Busy, Done, Start, ReadEn, Image, Filter and ResData SHALL all be 0.
REQ-038 Reset during a run SHALL abort it with no Done pulse; after release the block SHALL wait in IDLE for a new Go.

Verification
REQ-039 Load img = 1..7, flt = 1,2,3, pulse Go -> Start high 15 cycles with (Image,Filter) = (1,1),(2,2),(3,3),(2,1),(3,2),(4,3),...; res = 14,20,26,32,38; Done seen once.
REQ-040 All img = 15 and flt = 15 -> every res = 675.
REQ-041 Go pulsed during MULT and LoadEn pulsed during READ -> no restart, buffers unchanged, single Done.
REQ-042 rst_n asserted in cycle 8 of MULT -> outputs 0 asynchronously, no Done; a new load and Go then gives correct results.
REQ-043 RD_LAT = 3 with a bench model delaying ConvResult by 3 cycles -> same results as REQ-039 and Done two cycles later.
REQ-044 Two back-to-back runs with flt changed to 0,0,1 between them -> second res = 3,4,5,6,7.
